// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte FIFO feeding an 8N1 serial transmitter.
// In: clk, reset, wr_en, wr_data. Out: full, count, overflow, busy, tx.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  output logic                full,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
  output logic                busy,
  output logic                tx
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int PW    = DEPTH_LOG2;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [15:0]   TMAX    = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [15:0] timer;
  logic [15:0] timer_nx;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_idx_nx;
  logic [7:0]  shift;
  logic [7:0]  shift_nx;
  logic        tx_nx;

  logic bit_end;
  logic have_data;
  logic push;
  logic pop;

  assign have_data = (count != '0);
  assign full      = (count == DEPTH_C);
  assign busy      = (state != IDLE) || have_data;
  assign bit_end   = (timer == TMAX);

  // Full is judged on the registered count, so a pop
  // on the same edge never rescues a write.
  assign push = wr_en && !full;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (have_data) begin
          state_nx = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_nx = DATA;
        end
      end
      DATA: begin
        if (bit_end && bit_idx == 3'd7) begin
          state_nx = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nx = have_data ? START : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output / datapath control.
  // Frames chain straight from STOP into START when
  // bytes are waiting, so there is no idle gap.
  always_comb begin
    pop        = 1'b0;
    shift_nx   = shift;
    bit_idx_nx = bit_idx;
    timer_nx   = timer + 16'd1;
    if (state == IDLE || bit_end) begin
      timer_nx = '0;
    end
    unique case (state)
      IDLE: begin
        pop = have_data;
      end
      START: begin
        pop = 1'b0;
      end
      DATA: begin
        if (bit_end) begin
          shift_nx   = shift >> 1;
          bit_idx_nx = bit_idx + 3'd1;
        end
      end
      STOP: begin
        pop = bit_end && have_data;
      end
      default: pop = 1'b0;
    endcase
    if (pop) begin
      shift_nx = mem[rd_ptr];
    end
    tx_nx = 1'b1;
    unique case (state_nx)
      IDLE:    tx_nx = 1'b1;
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_nx[0];
      STOP:    tx_nx = 1'b1;
      default: tx_nx = 1'b1;
    endcase
  end

  // Serializer and FIFO bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer    <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      timer   <= timer_nx;
      bit_idx <= bit_idx_nx;
      shift   <= shift_nx;
      tx      <= tx_nx;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  a_count_max: assert property (
    @(posedge clk) disable iff (reset)
    count <= DEPTH_C
  );

  a_idle_high: assert property (
    @(posedge clk) disable iff (reset)
    (state == IDLE) |-> tx
  );

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, sets clk cycles per serial bit (100 MHz / 115200); legal range 2..65535.
REQ-002 Parameter DEPTH_LOG2, default 4, sets FIFO depth = 2**DEPTH_LOG2 bytes (16).
REQ-003 clk  input  1  Single clock; all state updates on its rising edge.
REQ-004 reset  input  1  Reset is asynchronous and active-high.
REQ-005 wr_en  input  1  Byte-write strobe from the memory-access stage (store to UART address), sampled each clk edge.
REQ-006 wr_data  input  8  Byte to transmit; valid when wr_en=1.
REQ-007 full  output  1  FIFO holds DEPTH bytes; combinational from registered count.
REQ-008 count  output  DEPTH_LOG2+1  Number of bytes currently queued, excluding the byte in flight.
REQ-009 overflow  output  1  Sticky flag: a write was dropped because FIFO was full.
REQ-010 busy  output  1  High when state!=IDLE or count!=0.
REQ-011 tx  output  1  Serial line, 8N1, LSB first, idle high; driven from a register.

Function
REQ-012 FIFO: circular buffer, write/read pointers DEPTH_LOG2 bits wide, wrap from DEPTH-1 to 0; count tracks occupancy 0..DEPTH.
REQ-013 Write accepted at an edge when wr_en=1 and full=0 at that edge; data stored at wr_ptr, wr_ptr++, count++.
REQ-014 Write with full=1 is dropped, FIFO unchanged, overflow set to 1 at that edge; a pop on the same edge does not rescue the write.
REQ-015 States: IDLE, START, DATA, STOP; 2-bit encoded state register.
REQ-016 IDLE: tx=1; if count!=0 at an edge, pop the head byte into an 8-bit shift register, rd_ptr++, count--, enter START, tx=0 from that edge.
REQ-017 Write into an empty FIFO is not popped on the same edge; the pop occurs on the following edge (first start-bit edge = write edge + 1 cycle).
REQ-018 Simultaneous accepted write and pop on one edge: count unchanged, both pointers advance.
REQ-019 Bit timer: counter 0..CLKS_PER_BIT-1, cleared on every state/bit change; each of START, 8 DATA bits and STOP lasts exactly CLKS_PER_BIT cycles.
REQ-020 START -> DATA after CLKS_PER_BIT cycles; tx=shift[0].
REQ-021 DATA: at each bit-period end, shift right, bit index++; after bit index 7 completes -> STOP, tx=1.
REQ-022 STOP end: if count!=0, pop next byte and enter START directly (no idle cycle between frames); else enter IDLE.
REQ-023 Frame length: exactly 10*CLKS_PER_BIT cycles; back-to-back frames are contiguous.
REQ-024 wr_en while transmitting is legal and independent of the serializer state.

Reset
REQ-025 reset=1 immediately (asynchronously) forces state=IDLE, tx=1, pointers=0, count=0, overflow=0, bit timer=0, bit index=0, shift register=0; full=0, busy=0.
REQ-026 Reset mid-frame aborts the frame: tx returns high without completing the stop bit; queued bytes are discarded.
REQ-027 Release of reset takes effect at the next clk edge; writes on that edge are accepted.

Verification (CLKS_PER_BIT=4 for benches)
REQ-028 Write 0xA5 once from reset -> tx low 1 cycle after write edge, then bits 1,0,1,0,0,1,0,1 (LSB first) each 4 cycles, stop high 4 cycles, busy drops after 40 cycles of frame.
REQ-029 Write 0x00, 0xFF on consecutive cycles -> two contiguous frames, 80 cycles, no idle gap; count goes 1,1,0.
REQ-030 With serializer held in first frame, write 17 bytes 0x01..0x11 back-to-back -> byte 0x01 popped, 0x02..0x11 fill FIFO (count=16, full=1); next write 0x12 dropped, overflow=1; transmitted sequence 0x01..0x11 exactly.
REQ-031 Fill to full, then write on the same edge a STOP ends (pop) -> write dropped, overflow=1, count=15.
REQ-032 Assert reset during DATA bit 3 of a frame with 5 bytes queued -> tx=1 immediately, count=0, busy=0; a new write 0x3C after release transmits 0x3C only.
REQ-033 Pointer wrap: transmit 40 bytes in bursts of 10 -> all bytes emitted in order, count returns to 0.
